mem_arbiter: RTL

//  Shares one slow 128-bit line memory between icache_wrapper and dcache_wrapper,
//  so the CHIP memory bus collapses to a single port. Accepts line requests,

---
 rtl/mem_arbiter.sv | 134 +++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing one 128-bit line memory between icache and dcache.
// The grant is held for a whole memory transaction, followed by a one-cycle response turnaround.
module mem_arbiter #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              proc_reset,
  input  logic              i_read,
  input  logic              i_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  served_i,
  output logic [CNT_W-1:0]  served_d
);

  // state  | meaning
  // S_IDLE | arbitrate between pending requests
  // S_BUSY | memory transaction in flight, mem_* held
  // S_RESP | one-cycle ready pulse to the winner, no arbitration
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

  state_t            r_state, w_state_nxt;
  logic              r_last_d, r_win_d;
  logic              r_mem_read, r_mem_write, r_busy;
  logic              r_i_ready, r_d_ready;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata, r_i_rdata, r_d_rdata;
  logic [CNT_W-1:0]  r_served_i, r_served_d;

  logic w_i_req, w_d_req, w_pick_d, w_pick_wr;
  logic w_grant, w_done, w_resp;

  assign w_i_req = i_read | i_write;
  assign w_d_req = d_read | d_write;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_i_req || w_d_req) w_state_nxt = S_BUSY;
      S_BUSY:  if (mem_ready)          w_state_nxt = S_RESP;
      S_RESP:                          w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  // On a tie the port that did not win last time goes first.
  always_comb begin
    w_pick_d  = w_d_req & (~w_i_req | ~r_last_d);
    w_pick_wr = w_pick_d ? d_write : i_write;
    w_grant   = (r_state == S_IDLE) && (w_i_req || w_d_req);
    w_done    = (r_state == S_BUSY) && mem_ready;
    w_resp    = (r_state == S_RESP);
  end

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      r_last_d    <= 1'b0;
      r_win_d     <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_i_rdata   <= '0;
      r_d_rdata   <= '0;
      r_i_ready   <= 1'b0;
      r_d_ready   <= 1'b0;
      r_busy      <= 1'b0;
      r_served_i  <= '0;
      r_served_d  <= '0;
    end else begin
      r_busy <= (w_state_nxt != S_IDLE);
      if (w_grant) begin
        r_win_d     <= w_pick_d;
        r_last_d    <= w_pick_d;
        r_mem_addr  <= w_pick_d ? d_addr  : i_addr;
        r_mem_wdata <= w_pick_d ? d_wdata : i_wdata;
        r_mem_write <= w_pick_wr;
        r_mem_read  <= ~w_pick_wr;
      end
      if (w_done) begin
        r_mem_read  <= 1'b0;
        r_mem_write <= 1'b0;
        if (r_win_d) begin
          r_d_ready  <= 1'b1;
          r_served_d <= r_served_d + 1'b1;
          if (!r_mem_write) r_d_rdata <= mem_rdata;
        end else begin
          r_i_ready  <= 1'b1;
          r_served_i <= r_served_i + 1'b1;
          if (!r_mem_write) r_i_rdata <= mem_rdata;
        end
      end
      if (w_resp) begin
        r_i_ready <= 1'b0;
        r_d_ready <= 1'b0;
      end
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign i_rdata   = r_i_rdata;
  assign d_rdata   = r_d_rdata;
  assign i_ready   = r_i_ready;
  assign d_ready   = r_d_ready;
  assign busy      = r_busy;
  assign served_i  = r_served_i;
  assign served_d  = r_served_d;

endmodule
